pc_sequencer: RTL and testbench

Program-counter sequencer for the 16-bit core. It owns the PC register and fetches each instruction over a request/acknowledge handshake with instruction memory. It waits for the execute stage to retire the instruction, then either advances the PC or redirects it. The redirect decision uses the jump condition codes; optionally a hardware return-address stack serves CALL/RET.

---
 rtl/pc_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter sequencer with imem fetch handshake and jump
//            resolution; optional return-address stack (PC_CALL_STACK_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_ready,
  input  logic        exec_valid,
  input  logic        is_jump,
  input  logic [2:0]  jump_operator,
  input  logic [15:0] test_value,
  input  logic [15:0] dest_address,
  input  logic        halt,
  output logic [15:0] pc,
  output logic        branch_taken,
  output logic        stack_err
);

  if (STACK_DEPTH < 2 || STACK_DEPTH > 16 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_depth_check
    $error("pc_sequencer: STACK_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_pc;
  logic [15:0] w_next_pc;
  logic [15:0] w_pc_inc;
  logic [15:0] w_target;
  logic        w_cond;
  logic        w_taken;
  logic        r_instr_ready;
  logic        r_branch_taken;
  logic        w_push;
  logic        w_pop;
  logic        w_err_set;

`ifdef PC_CALL_STACK_EN
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] c_sp_full = SP_W'(STACK_DEPTH);

  logic [15:0]      r_stack [STACK_DEPTH];
  logic [SP_W-1:0]  r_sp;
  logic             r_stack_err;
  logic             w_full;
  logic             w_empty;
  logic [IDX_W-1:0] w_push_idx;
  logic [IDX_W-1:0] w_top_idx;

  assign w_full     = (r_sp == c_sp_full);
  assign w_empty    = (r_sp == '0);
  assign w_push_idx = r_sp[IDX_W-1:0];
  assign w_top_idx  = r_sp[IDX_W-1:0] - IDX_W'(1);
`endif

  assign w_pc_inc = r_pc + 16'd1;

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_target     = dest_address;
    w_cond       = 1'b0;
    w_taken      = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      S_IDLE:  w_next_state = S_FETCH;
      S_FETCH: if (imem_ack) w_next_state = S_EXEC;
      S_EXEC: begin
        if (exec_valid) begin
          if (halt) begin
            w_next_state = S_HALTED;
          end else begin
            w_next_state = S_FETCH;
            if (is_jump) begin
              case (jump_operator)
                3'b000: w_cond = 1'b1;
                3'b001: w_cond = (test_value == 16'h0000);
                3'b010: w_cond = (test_value != 16'h0000);
                3'b011: w_cond = !test_value[15] && (test_value != 16'h0000);
                3'b100: w_cond = test_value[15];
`ifdef PC_CALL_STACK_EN
                // A CALL on a full stack still jumps; only the return address is lost.
                3'b101: begin
                  w_cond    = 1'b1;
                  w_push    = !w_full;
                  w_err_set = w_full;
                end
                3'b110: begin
                  w_cond    = !w_empty;
                  w_pop     = !w_empty;
                  w_err_set = w_empty;
                  w_target  = r_stack[w_top_idx];
                end
`endif
                default: w_cond = 1'b0;
              endcase
            end
            w_taken   = w_cond;
            w_next_pc = w_cond ? w_target : w_pc_inc;
          end
        end
      end
      S_HALTED: w_next_state = S_HALTED;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_PC;
      r_instr_ready  <= 1'b0;
      r_branch_taken <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_pc           <= w_next_pc;
      r_instr_ready  <= (r_state == S_FETCH) && imem_ack;
      r_branch_taken <= w_taken;
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp        <= '0;
      r_stack_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_sp <= r_sp + SP_W'(1);
      end else if (w_pop) begin
        r_sp <= r_sp - SP_W'(1);
      end
      if (w_err_set) r_stack_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_push_idx] <= w_pc_inc;
  end

  assign stack_err = r_stack_err;
`else
  assign stack_err = 1'b0;
`endif

  assign imem_req     = (r_state == S_FETCH);
  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign instr_ready  = r_instr_ready;
  assign branch_taken = r_branch_taken;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer; directed plan plus random
//            instruction stream against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  localparam logic [15:0] c_reset_pc = 16'h0010;
  localparam int          c_depth    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        instr_ready;
  logic        exec_valid = 1'b0;
  logic        is_jump = 1'b0;
  logic [2:0]  jump_operator = 3'd0;
  logic [15:0] test_value = 16'd0;
  logic [15:0] dest_address = 16'd0;
  logic        halt = 1'b0;
  logic [15:0] pc;
  logic        branch_taken;
  logic        stack_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] exp_pc;
  logic [15:0] stk[$];
  logic        exp_err;
  logic        exp_halted;
  logic        exp_taken;

  pc_sequencer #(
    .RESET_PC    (c_reset_pc),
    .STACK_DEPTH (c_depth)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .instr_ready  (instr_ready),
    .exec_valid   (exec_valid),
    .is_jump      (is_jump),
    .jump_operator(jump_operator),
    .test_value   (test_value),
    .dest_address (dest_address),
    .halt         (halt),
    .pc           (pc),
    .branch_taken (branch_taken),
    .stack_err    (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of retiring one instruction.
  task automatic model_retire(input logic j, input logic [2:0] op, input logic [15:0] tv,
                              input logic [15:0] dst, input logic h);
    logic [15:0] tgt;
    logic        tk;
    tk  = 1'b0;
    tgt = dst;
    if (h) begin
      exp_halted = 1'b1;
    end else begin
      if (j) begin
        case (op)
          3'd0: tk = 1'b1;
          3'd1: tk = (tv == 16'd0);
          3'd2: tk = (tv != 16'd0);
          3'd3: tk = ($signed(tv) > 0);
          3'd4: tk = ($signed(tv) < 0);
`ifdef PC_CALL_STACK_EN
          3'd5: begin
            tk = 1'b1;
            if (stk.size() == c_depth) exp_err = 1'b1;
            else stk.push_back(exp_pc + 16'd1);
          end
          3'd6: begin
            if (stk.size() == 0) exp_err = 1'b1;
            else begin
              tk  = 1'b1;
              tgt = stk.pop_back();
            end
          end
`endif
          default: tk = 1'b0;
        endcase
      end
      exp_pc = tk ? tgt : exp_pc + 16'd1;
    end
    exp_taken = tk;
  endtask

  // Called #1 after an edge, with the DUT expected in FETCH.
  task automatic do_instr(input int ack_dly, input int ex_dly, input logic j, input logic [2:0] op,
                          input logic [15:0] tv, input logic [15:0] dst, input logic h);
    for (int i = 0; i < ack_dly; i++) begin
      check("fetch_req", 16'(imem_req), 16'd1);
      check("fetch_addr", imem_addr, exp_pc);
      exec_valid    = 1'($urandom % 2);
      halt          = 1'b1;
      is_jump       = 1'b1;
      jump_operator = 3'd0;
      dest_address  = 16'h1234;
      step();
      check("fetch_rdy", 16'(instr_ready), 16'd0);
      check("fetch_bt", 16'(branch_taken), 16'd0);
    end
    exec_valid = 1'b0;
    halt       = 1'b0;
    check("ack_req", 16'(imem_req), 16'd1);
    check("ack_addr", imem_addr, exp_pc);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("exec_rdy", 16'(instr_ready), 16'd1);
    check("exec_req", 16'(imem_req), 16'd0);
    check("exec_pc", pc, exp_pc);
    for (int i = 0; i < ex_dly; i++) begin
      imem_ack = 1'($urandom % 2);
      step();
      imem_ack = 1'b0;
      check("wait_rdy", 16'(instr_ready), 16'd0);
      check("wait_req", 16'(imem_req), 16'd0);
      check("wait_pc", pc, exp_pc);
    end
    exec_valid    = 1'b1;
    is_jump       = j;
    jump_operator = op;
    test_value    = tv;
    dest_address  = dst;
    halt          = h;
    model_retire(j, op, tv, dst, h);
    step();
    exec_valid = 1'b0;
    halt       = 1'b0;
    is_jump    = 1'b0;
    check("ret_pc", pc, exp_pc);
    check("ret_bt", 16'(branch_taken), 16'(exp_taken));
    check("ret_req", 16'(imem_req), 16'(!exp_halted));
    check("ret_err", 16'(stack_err), 16'(exp_err));
    check("ret_rdy", 16'(instr_ready), 16'd0);
  endtask

  // Asserts reset mid-cycle and checks the asynchronous response and restart.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_pc", pc, c_reset_pc);
    check("rst_req", 16'(imem_req), 16'd0);
    check("rst_rdy", 16'(instr_ready), 16'd0);
    check("rst_bt", 16'(branch_taken), 16'd0);
    check("rst_err", 16'(stack_err), 16'd0);
    step();
    rst = 1'b0;
    exp_pc     = c_reset_pc;
    exp_err    = 1'b0;
    exp_halted = 1'b0;
    stk.delete();
    check("rel_req0", 16'(imem_req), 16'd0);
    step();
    check("rel_req1", 16'(imem_req), 16'd1);
    check("rel_addr", imem_addr, c_reset_pc);
  endtask

  function automatic logic [15:0] pick_tv();
    case ($urandom % 6)
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    exp_pc     = c_reset_pc;
    exp_err    = 1'b0;
    exp_halted = 1'b0;
    exp_taken  = 1'b0;
    step();
    do_reset();

    // Straight-line fetch at the minimum period.
    for (int i = 0; i < 3; i++) do_instr(0, 0, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
    // Slow memory.
    do_instr(5, 2, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);

    do_instr(0, 0, 1'b1, 3'd4, 16'h8000, 16'h0200, 1'b0);
    do_instr(0, 0, 1'b1, 3'd3, 16'hFFFF, 16'h0200, 1'b0);
    do_instr(0, 0, 1'b1, 3'd1, 16'h0000, 16'h0200, 1'b0);
    do_instr(1, 1, 1'b1, 3'd7, 16'h0000, 16'h0300, 1'b0);

    // PC wrap.
    do_instr(0, 0, 1'b1, 3'd0, 16'd0, 16'hFFFF, 1'b0);
    do_instr(0, 0, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);

    // Call/return; without the stack these retire to pc+1.
    do_instr(0, 0, 1'b1, 3'd0, 16'd0, 16'h0005, 1'b0);
    do_instr(0, 0, 1'b1, 3'd5, 16'd0, 16'h0100, 1'b0);
    do_instr(0, 0, 1'b1, 3'd6, 16'd0, 16'h0777, 1'b0);
    for (int i = 0; i < 5; i++) do_instr(0, 0, 1'b1, 3'd5, 16'd0, 16'(16'h0400 + 16 * i), 1'b0);
    for (int i = 0; i < 5; i++) do_instr(0, 1, 1'b1, 3'd6, 16'd0, 16'h0999, 1'b0);

    do_reset();
    for (int n = 0; n < 200; n++) begin
      logic [2:0] op;
      op = 3'($urandom % 8);
      do_instr(int'($urandom % 3), int'($urandom % 3), 1'($urandom % 10 < 7), op,
               pick_tv(), 16'($urandom), 1'b0);
    end

    // Halt beats a simultaneous jump; HALTED ignores acks.
    do_instr(0, 0, 1'b1, 3'd0, 16'd0, 16'h0ABC, 1'b1);
    for (int i = 0; i < 4; i++) begin
      imem_ack   = 1'b1;
      exec_valid = 1'b1;
      step();
      check("hlt_req", 16'(imem_req), 16'd0);
      check("hlt_pc", pc, exp_pc);
      check("hlt_rdy", 16'(instr_ready), 16'd0);
    end
    imem_ack   = 1'b0;
    exec_valid = 1'b0;

    do_reset();
    do_instr(0, 0, 1'b1, 3'd0, 16'd0, 16'h0040, 1'b0);
    // Reset while sitting in EXEC.
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("pre_rst_rdy", 16'(instr_ready), 16'd1);
    do_reset();
    do_instr(0, 0, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
